// File: rtl/fetch_queue_pkg.sv
// Shared constants, entry payload type and sizing helper for the fetch queue.
package fetch_queue_pkg;

    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned PC_W_DEF    = 8;

    // Bubble word presented to decode while the queue is empty.
    localparam logic [INSTR_W_DEF-1:0] NOP_WORD = 32'h0000_0000;

    // One buffered fetch: instruction plus the next-PC that goes with it.
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    pc;
    } fq_entry_t;

    // Pointer width for a circular buffer of the given depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side / decode-side handshake bundle of the prefetch queue.
interface fetch_queue_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               in_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready;
    logic               flush;
    logic               almost_full;
    logic [CNT_W-1:0]   count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, flush,
        input  in_ready, out_valid, out_instr, out_pc, almost_full, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, flush,
        output in_ready, out_valid, out_instr, out_pc, almost_full, count
    );

endinterface

// File: rtl/fq_mem.sv
// Entry storage: synchronous write, asynchronous read, contents never reset.
module fq_mem #(
    parameter int unsigned W     = 40,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port: one entry per clock when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and the IF/ID register.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        PC_W      = 8,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_WORD)
) (
    input  logic         Clk,
    input  logic         Clr_n,
    fetch_queue_if.slave bus
);

    localparam int unsigned PTR_W   = ptr_w(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = INSTR_W + PC_W;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic             not_full;
    entry_t           wr_entry;
    entry_t           rd_entry;

    // Flags come from registered occupancy only.
    assign not_empty = (count_q != '0);
    assign not_full  = (count_q < CNT_W'(DEPTH));

    // Flush wins over both handshakes in the same cycle.
    assign push = bus.in_valid && not_full && !bus.flush;
    assign pop  = not_empty && bus.out_ready && !bus.flush;

    assign wr_entry = '{instr: bus.in_instr, pc: bus.in_pc};

    fq_mem #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (Clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Pointer and occupancy update; power-of-two depth wraps naturally.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign bus.in_ready    = not_full;
    assign bus.out_valid   = not_empty;
    assign bus.almost_full = (count_q >= CNT_W'(DEPTH - 1));
    assign bus.count       = count_q;

    // Head is read through; an empty queue shows a bubble instead of stale data.
    assign bus.out_instr = not_empty ? rd_entry.instr : NOP_INSTR;
    assign bus.out_pc    = not_empty ? rd_entry.pc    : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with DEPTH=4.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk;
    logic clr_n;

    int unsigned n_total;
    int unsigned n_pass;

    fq_entry_t fill [4];

    fetch_queue_if #(.INSTR_W(32), .PC_W(8), .DEPTH(4)) bus ();

    fetch_queue #(
        .INSTR_W   (32),
        .PC_W      (8),
        .DEPTH     (4),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .Clk   (clk),
        .Clr_n (clr_n),
        .bus   (bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [7:0] pc);
        bus.in_valid = v;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic [7:0] pc);
        check({tag, "_instr"}, 64'(bus.out_instr), 64'(instr));
        check({tag, "_pc"},    64'(bus.out_pc),    64'(pc));
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        clk     = 1'b0;
        clr_n   = 1'b0;
        fill[0] = '{instr: 32'hE3A0_1005, pc: 8'd4};
        fill[1] = '{instr: 32'hE281_1001, pc: 8'd8};
        fill[2] = '{instr: 32'hE081_2002, pc: 8'd12};
        fill[3] = '{instr: 32'hE580_3000, pc: 8'd16};
        drive(1'b0, 32'h0, 8'h0);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // Reset state.
        #3;
        check("rst_count",    64'(bus.count),       64'd0);
        check("rst_valid",    64'(bus.out_valid),   64'd0);
        check("rst_in_ready", 64'(bus.in_ready),    64'd1);
        check("rst_afull",    64'(bus.almost_full), 64'd0);
        check_head("rst_head", 32'h0, 8'h0);
        @(negedge clk);
        clr_n = 1'b1;
        tick();

        // Fill with a stalled consumer.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill[i].instr, fill[i].pc);
            tick();
            check($sformatf("fill%0d_count", i), 64'(bus.count), 64'(i + 1));
            check($sformatf("fill%0d_afull", i), 64'(bus.almost_full), (i >= 2) ? 64'd1 : 64'd0);
        end
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check_head("fill_head", 32'hE3A0_1005, 8'd4);

        // Fifth push while full is ignored.
        drive(1'b1, 32'hDEAD_BEEF, 8'd20);
        tick();
        check("over_count", 64'(bus.count), 64'd4);
        check_head("over_head", 32'hE3A0_1005, 8'd4);

        // Full with push and pop together: only the pop happens.
        bus.out_ready = 1'b1;
        #1;
        check("full_rdy_indep", 64'(bus.in_ready), 64'd0);
        tick();
        check("fpp_count",    64'(bus.count),    64'd3);
        check("fpp_in_ready", 64'(bus.in_ready), 64'd1);
        check_head("fpp_head", 32'hE281_1001, 8'd8);
        drive(1'b0, 32'h0, 8'h0);
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-cycle with count=3.
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_count",    64'(bus.count),     64'd0);
        check("arst_valid",    64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready),  64'd1);
        check_head("arst_head", 32'h0, 8'h0);
        #1;
        clr_n = 1'b1;
        tick();

        // Streaming 10 words through, wrapping the pointers.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1000_0000 + 32'(i), 8'(4 * i + 4));
            tick();
            check($sformatf("strm%0d_count", i), 64'(bus.count), 64'd1);
            check_head($sformatf("strm%0d", i), 32'h1000_0000 + 32'(i), 8'(4 * i + 4));
        end
        drive(1'b0, 32'h0, 8'h0);
        tick();
        check("strm_drain_count", 64'(bus.count), 64'd0);
        check("strm_drain_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Flush at count=2 with push and pop offered.
        drive(1'b1, 32'hAAAA_0001, 8'h20);
        tick();
        drive(1'b1, 32'hAAAA_0002, 8'h24);
        tick();
        check("pre_flush_count", 64'(bus.count), 64'd2);
        drive(1'b1, 32'hC0FF_EE00, 8'h28);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        tick();
        check("flush_count",    64'(bus.count),     64'd0);
        check("flush_valid",    64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready),  64'd1);
        check_head("flush_head", 32'h0, 8'h0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 8'h0);
        tick();
        check("post_flush_count", 64'(bus.count), 64'd0);
        drive(1'b1, 32'hDDDD_0004, 8'h30);
        tick();
        drive(1'b0, 32'h0, 8'h0);
        check("post_flush_push_count", 64'(bus.count), 64'd1);
        check_head("post_flush_head", 32'hDDDD_0004, 8'h30);

        // Drain, then pop while empty.
        bus.out_ready = 1'b1;
        tick();
        check("drain_count", 64'(bus.count), 64'd0);
        tick();
        check("empty_pop_count", 64'(bus.count),     64'd0);
        check("empty_pop_valid", 64'(bus.out_valid), 64'd0);
        check_head("empty_pop_head", 32'h0, 8'h0);

        // Push while out_ready is held on an empty queue.
        drive(1'b1, 32'hEEEE_0005, 8'h34);
        tick();
        drive(1'b0, 32'h0, 8'h0);
        check("empty_push_count", 64'(bus.count), 64'd1);
        check_head("empty_push_head", 32'hEEEE_0005, 8'h34);
        tick();
        check("final_count", 64'(bus.count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
